// File: rtl/key_arb_pkg.sv
// Shared types and defaults for the key-search result arbiter.
package key_arb_pkg;

    localparam int KEY_W_DEF     = 24;
    localparam int NUM_CORES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FOUND  = 2'd2,
        FAILED = 2'd3
    } arb_state_t;

endpackage

// File: rtl/lowest_set_priority_enc.sv
// Combinational priority encoder: index of the lowest set bit plus an any flag.
module lowest_set_priority_enc #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0] vec,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/key_result_arbiter.sv
// Picks the first successful RC4 search core, latches its key, halts the array
// and drives the registered key (or a live debug view) to the HEX display path.
module key_result_arbiter
    import key_arb_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int KEY_W     = KEY_W_DEF,
    parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [NUM_CORES-1:0]       core_success,
    input  logic [NUM_CORES*KEY_W-1:0] core_key,
    input  logic                       view_mode,
    input  logic [IDX_W-1:0]           view_idx,
    output logic                       stop_cores,
    output logic                       searching,
    output logic                       key_valid,
    output logic                       all_failed,
    output logic [IDX_W-1:0]           winner_idx,
    output logic [KEY_W-1:0]           secret_key
);

    arb_state_t           state, state_nx;
    logic [NUM_CORES-1:0] done_mask, done_mask_nx;
    logic [KEY_W-1:0]     latched_key, latched_key_nx;
    logic [IDX_W-1:0]     winner_nx;
    logic [KEY_W-1:0]     secret_nx;

    logic [NUM_CORES-1:0] hit;
    logic [IDX_W-1:0]     hit_idx;
    logic                 hit_any;
    logic [KEY_W-1:0]     hit_key;
    logic [KEY_W-1:0]     view_key;

    assign hit = core_done & core_success;

    lowest_set_priority_enc #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_hit_enc (
        .vec (hit),
        .idx (hit_idx),
        .any (hit_any)
    );

    // Index compares instead of a variable part-select keep out-of-range
    // view_idx values (>= NUM_CORES) reading as zero.
    always_comb begin
        hit_key  = '0;
        view_key = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (hit_idx == IDX_W'(i))  hit_key  = core_key[i*KEY_W +: KEY_W];
            if (view_idx == IDX_W'(i)) view_key = core_key[i*KEY_W +: KEY_W];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nx       = state;
        done_mask_nx   = done_mask;
        latched_key_nx = latched_key;
        winner_nx      = winner_idx;
        if (start) begin
            // A restart outranks a hit seen in the same cycle.
            state_nx       = SEARCH;
            done_mask_nx   = '0;
            latched_key_nx = '0;
            winner_nx      = '0;
        end else if (state == SEARCH) begin
            done_mask_nx = done_mask | core_done;
            if (hit_any) begin
                state_nx       = FOUND;
                latched_key_nx = hit_key;
                winner_nx      = hit_idx;
            end else if (&done_mask_nx) begin
                state_nx = FAILED;
            end
        end

        // Derived from next-state values so the display updates with key_valid.
        if (view_mode)               secret_nx = view_key;
        else if (state_nx == FOUND)  secret_nx = latched_key_nx;
        else                         secret_nx = '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            done_mask   <= '0;
            latched_key <= '0;
            winner_idx  <= '0;
            secret_key  <= '0;
        end else begin
            state       <= state_nx;
            done_mask   <= done_mask_nx;
            latched_key <= latched_key_nx;
            winner_idx  <= winner_nx;
            secret_key  <= secret_nx;
        end
    end

    assign searching  = (state == SEARCH);
    assign key_valid  = (state == FOUND);
    assign all_failed = (state == FAILED);
    assign stop_cores = (state == FOUND) || (state == FAILED);

endmodule
